// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one multicycle memory port among N_PORTS requesters.
// Only one transaction is in flight; mem_* outputs come only from registers latched at grant.
module mem_port_arbiter #(
  parameter int N_PORTS    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_PORTS-1:0]               req_read,
  input  logic [N_PORTS-1:0]               req_write,
  input  logic [N_PORTS*BE_WIDTH-1:0]      req_byte_enable,
  input  logic [N_PORTS*ADDR_WIDTH-1:0]    req_address,
  input  logic [N_PORTS*DATA_WIDTH-1:0]    req_wdata,
  output logic [DATA_WIDTH-1:0]            req_rdata,
  output logic [N_PORTS-1:0]               req_resp,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [BE_WIDTH-1:0]              mem_byte_enable,
  output logic [ADDR_WIDTH-1:0]            mem_address,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  input  logic                             mem_resp,
  output logic [$clog2(N_PORTS)-1:0]       grant_id,
  output logic                             busy
);

  localparam int ID_W = $clog2(N_PORTS);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       grant_q, grant_d;
  logic [ID_W-1:0]       last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_WIDTH-1:0]   be_q, be_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;

  logic [N_PORTS-1:0]    req_any;
  logic                  win_valid;
  logic [ID_W-1:0]       win_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N_PORTS; gi++) begin : g_req_any
      assign req_any[gi] = req_read[gi] | req_write[gi];
    end
  endgenerate

  // Scan ports starting just after the previous owner; first hit wins.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] cand;
    idx       = 0;
    cand      = '0;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int off = 1; off <= N_PORTS; off++) begin
      idx = int'(last_grant_q) + off;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      cand = idx[ID_W-1:0];
      if (!win_valid && req_any[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    read_d       = read_q;
    write_d      = write_q;
    if (state_q == IDLE) begin
      if (win_valid) begin
        state_d = BUSY;
        grant_d = win_idx;
        addr_d  = req_address[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_d = req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
        be_d    = req_byte_enable[win_idx*BE_WIDTH +: BE_WIDTH];
        // A port asserting both strobes gets a write; its read is dropped.
        write_d = req_write[win_idx];
        read_d  = req_read[win_idx] & ~req_write[win_idx];
      end
    end else begin
      if (mem_resp) begin
        state_d      = IDLE;
        read_d       = 1'b0;
        write_d      = 1'b0;
        last_grant_d = grant_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_W'(N_PORTS - 1);
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      read_q       <= read_d;
      write_q      <= write_d;
    end
  end

  always_comb begin
    req_resp = '0;
    if (state_q == BUSY && mem_resp) req_resp[grant_q] = 1'b1;
  end

  assign req_rdata       = mem_rdata;
  assign mem_read        = read_q;
  assign mem_write       = write_q;
  assign mem_address     = addr_q;
  assign mem_wdata       = wdata_q;
  assign mem_byte_enable = be_q;
  assign grant_id        = grant_q;
  assign busy            = (state_q == BUSY);

endmodule
